// File: rtl/clock_switch_ctrl_if.sv
// Request channel from housekeeping into clock_switch_ctrl.
// Handshake: the master holds req_valid and the payload (req_use_pll, req_sel,
// req_sel2, settle_cycles) stable until a rising edge where req_valid and
// req_ready are both high; that edge is the transfer. req_ready is only high
// while the controller is idle, and req_valid is ignored whenever it is low.
interface clock_switch_ctrl_if #(
    parameter int SETTLE_W = 16
);
    logic                req_valid;
    logic                req_ready;
    logic                req_use_pll;
    logic [2:0]          req_sel;
    logic [2:0]          req_sel2;
    logic [SETTLE_W-1:0] settle_cycles;

    modport master (
        output req_valid, req_use_pll, req_sel, req_sel2, settle_cycles,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_use_pll, req_sel, req_sel2, settle_cycles,
        output req_ready
    );
endinterface

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: sequences a runtime reprogramming of the core clocking
// block from the always-present pad clock: hold reset, park on the external
// clock, load dividers, wait for the PLL, switch, release reset.
// Optional build macro CLKSW_LOCK_CHECK_EN: SETTLE exits early on pll_lock
// and a settle timeout skips the switch and raises the sticky err flag.
// All outputs are registered from the current state, so each output change
// appears one edge after the state that causes it.
module clock_switch_ctrl #(
    parameter int SETTLE_W    = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                ext_clk,
    input  logic                resetb,
    clock_switch_ctrl_if.slave  req,
    input  logic                pll_lock,
    output logic                ext_clk_sel,
    output logic [2:0]          sel,
    output logic [2:0]          sel2,
    output logic                ext_reset,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT_RST = 3'd1,
        TO_EXT     = 3'd2,
        PROGRAM    = 3'd3,
        SETTLE     = 3'd4,
        SWITCH     = 3'd5,
        RELEASE    = 3'd6
    } state_t;

    // Counters are loaded with (duration - 1) on entry and leave at zero.
    localparam logic [SETTLE_W-1:0] HOLD_LOAD  = SETTLE_W'(HOLD_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] DRAIN_LOAD = SETTLE_W'(3);

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic                cap_use_pll_q, cap_use_pll_d;
    logic [2:0]          cap_sel_q, cap_sel_d;
    logic [2:0]          cap_sel2_q, cap_sel2_d;
    logic [SETTLE_W-1:0] cap_settle_q, cap_settle_d;
    logic                ext_clk_sel_q, ext_clk_sel_d;
    logic [2:0]          sel_q, sel_d;
    logic [2:0]          sel2_q, sel2_d;
    logic                ext_reset_q, ext_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                req_ready_q, req_ready_d;
    logic                accept;
    logic                in_seq;

`ifndef CLKSW_LOCK_CHECK_EN
    // Lock indicator is only consulted by the lock-checking build.
    logic unused_pll_lock;
    assign unused_pll_lock = pll_lock;
`endif

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_use_pll_d = cap_use_pll_q;
        cap_sel_d     = cap_sel_q;
        cap_sel2_d    = cap_sel2_q;
        cap_settle_d  = cap_settle_q;
        err_d         = err_q;
        accept        = req.req_valid && req_ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = ASSERT_RST;
                    cnt_d         = HOLD_LOAD;
                    cap_use_pll_d = req.req_use_pll;
                    cap_sel_d     = req.req_sel;
                    cap_sel2_d    = req.req_sel2;
                    cap_settle_d  = req.settle_cycles;
                    err_d         = 1'b0;
                end
            end
            ASSERT_RST: begin
                if (cnt_q == '0) begin
                    state_d = TO_EXT;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            TO_EXT: begin
                if (cnt_q == '0) state_d = PROGRAM;
                else             cnt_d   = cnt_q - SETTLE_W'(1);
            end
            PROGRAM: begin
                if (cap_use_pll_q) begin
                    state_d = SETTLE;
                    // A settle request of zero still waits one cycle.
                    cnt_d   = (cap_settle_q == '0) ? '0 : cap_settle_q - SETTLE_W'(1);
                end else begin
                    state_d = RELEASE;
                end
            end
            SETTLE: begin
`ifdef CLKSW_LOCK_CHECK_EN
                if (pll_lock) begin
                    state_d = SWITCH;
                    cnt_d   = DRAIN_LOAD;
                end else if (cnt_q == '0) begin
                    // No lock in time: stay on the external clock.
                    state_d = RELEASE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
`else
                if (cnt_q == '0) begin
                    state_d = SWITCH;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
`endif
            end
            SWITCH: begin
                if (cnt_q == '0) state_d = RELEASE;
                else             cnt_d   = cnt_q - SETTLE_W'(1);
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_seq = state_q inside {ASSERT_RST, TO_EXT, PROGRAM, SETTLE, SWITCH};

        ext_reset_d   = in_seq;
        busy_d        = in_seq;
        done_d        = (state_q == RELEASE);
        req_ready_d   = (state_q == IDLE) && !accept;
        ext_clk_sel_d = ext_clk_sel_q;
        sel_d         = sel_q;
        sel2_d        = sel2_q;
        if (state_q == TO_EXT) ext_clk_sel_d = 1'b1;
        if (state_q == SWITCH) ext_clk_sel_d = 1'b0;
        if (state_q == PROGRAM) begin
            sel_d  = cap_sel_q;
            sel2_d = cap_sel2_q;
        end
    end

    // State, capture and output registers; reset parks on the external clock.
    always_ff @(posedge ext_clk) begin
        if (!resetb) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cap_use_pll_q <= 1'b0;
            cap_sel_q     <= 3'd0;
            cap_sel2_q    <= 3'd0;
            cap_settle_q  <= '0;
            ext_clk_sel_q <= 1'b1;
            sel_q         <= 3'd0;
            sel2_q        <= 3'd0;
            ext_reset_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_use_pll_q <= cap_use_pll_d;
            cap_sel_q     <= cap_sel_d;
            cap_sel2_q    <= cap_sel2_d;
            cap_settle_q  <= cap_settle_d;
            ext_clk_sel_q <= ext_clk_sel_d;
            sel_q         <= sel_d;
            sel2_q        <= sel2_d;
            ext_reset_q   <= ext_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign req.req_ready = req_ready_q;
    assign ext_clk_sel   = ext_clk_sel_q;
    assign sel           = sel_q;
    assign sel2          = sel2_q;
    assign ext_reset     = ext_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl (HOLD_CYCLES=4, SETTLE_W=16).
// Cycle c of a request means "sampled #1 after the c-th edge following the
// accept edge E0" (c=0 is just after E0).
module tb_clock_switch_ctrl;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_SWITCH = 3'd5;
  localparam int MAXC = 128;

  logic       ext_clk;
  logic       resetb;
  logic       pll_lock;
  logic       ext_clk_sel;
  logic [2:0] sel;
  logic [2:0] sel2;
  logic       ext_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  clock_switch_ctrl_if #(.SETTLE_W(16)) ifc ();

  clock_switch_ctrl #(.SETTLE_W(16), .HOLD_CYCLES(4)) dut (
    .ext_clk    (ext_clk),
    .resetb     (resetb),
    .req        (ifc),
    .pll_lock   (pll_lock),
    .ext_clk_sel(ext_clk_sel),
    .sel        (sel),
    .sel2       (sel2),
    .ext_reset  (ext_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic       rec_ecs   [0:MAXC-1];
  logic [2:0] rec_sel   [0:MAXC-1];
  logic [2:0] rec_sel2  [0:MAXC-1];
  logic       rec_rst   [0:MAXC-1];
  logic       rec_busy  [0:MAXC-1];
  logic       rec_done  [0:MAXC-1];
  logic       rec_err   [0:MAXC-1];
  logic       rec_ready [0:MAXC-1];
  logic [2:0] rec_state [0:MAXC-1];

  // Clock and time-limit guard
  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic record(input int c);
    rec_ecs[c]   = ext_clk_sel;
    rec_sel[c]   = sel;
    rec_sel2[c]  = sel2;
    rec_rst[c]   = ext_reset;
    rec_busy[c]  = busy;
    rec_done[c]  = done;
    rec_err[c]   = err;
    rec_ready[c] = ifc.req_ready;
    rec_state[c] = state_dbg;
  endtask

  function automatic int first_done(input int n);
    int f = -1;
    for (int c = 0; c <= n; c++) if (rec_done[c] === 1'b1 && f < 0) f = c;
    return f;
  endfunction

  function automatic int count_done(input int n);
    int k = 0;
    for (int c = 0; c <= n; c++) if (rec_done[c] === 1'b1) k++;
    return k;
  endfunction

  function automatic int first_ecs_low(input int n);
    int f = -1;
    for (int c = 0; c <= n; c++) if (rec_ecs[c] === 1'b0 && f < 0) f = c;
    return f;
  endfunction

  // Bounded wait for req_ready; returns #1 after an edge.
  task automatic wait_ready();
    int n = 0;
    while (ifc.req_ready !== 1'b1 && n < 300) begin
      @(posedge ext_clk); #1;
      n++;
    end
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: req_ready=%b, required 1 within 300 cycles", ifc.req_ready);
    end
  endtask

  // Driver: issue one request, then record outputs for cycles 0..ncyc.
  // pll_lock goes high after cycle lock_at (negative: never).
  task automatic run_req(input logic use_pll, input logic [2:0] s, input logic [2:0] s2,
                         input logic [15:0] st, input int ncyc, input int lock_at);
    wait_ready();
    pll_lock          = 1'b0;
    ifc.req_valid     = 1'b1;
    ifc.req_use_pll   = use_pll;
    ifc.req_sel       = s;
    ifc.req_sel2      = s2;
    ifc.settle_cycles = st;
    @(posedge ext_clk); #1;
    ifc.req_valid     = 1'b0;
    ifc.req_sel       = 3'd0;
    ifc.req_sel2      = 3'd0;
    record(0);
    for (int c = 1; c <= ncyc; c++) begin
      if (c - 1 == lock_at) pll_lock = 1'b1;
      @(posedge ext_clk); #1;
      record(c);
    end
    pll_lock = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    resetb        = 1'b0;
    ifc.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ext_clk); #1;
      obs = {ext_clk_sel, sel, sel2, ext_reset, busy, done, err, ifc.req_ready};
      checks++;
      if (obs !== 12'b1_000_000_0_0_0_0_0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b, required 100000000000", i, obs);
      end
    end
    resetb = 1'b1;
    @(posedge ext_clk); #1;
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got %b, required 1", ifc.req_ready);
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state_idle: got %0d, required 0", state_dbg);
    end
  endtask

  task automatic test_ext_only();
    int bad_ecs = 0, bad_rst = 0, bad_busy = 0;
    run_req(1'b0, 3'd3, 3'd1, 16'd7, 14, -1);
    for (int c = 0; c <= 14; c++) begin
      if (rec_ecs[c] !== 1'b1) bad_ecs++;
      if (rec_rst[c] !== (c >= 1 && c <= 9)) bad_rst++;
      if (rec_busy[c] !== (c >= 1 && c <= 9)) bad_busy++;
    end
    checks++;
    if (rec_ready[0] !== 1'b0) begin errors++; $display("FAIL ext_ready_drop: got %b, required 0", rec_ready[0]); end
    checks++;
    if (first_done(14) != 10) begin errors++; $display("FAIL ext_done_cycle: got %0d, required 10", first_done(14)); end
    checks++;
    if (count_done(14) != 1) begin errors++; $display("FAIL ext_done_count: got %0d, required 1", count_done(14)); end
    checks++;
    if (bad_ecs != 0) begin errors++; $display("FAIL ext_clk_sel_held: %0d cycles not 1, required 0", bad_ecs); end
    checks++;
    if (bad_rst != 0) begin errors++; $display("FAIL ext_reset_window: %0d cycles wrong, required 0", bad_rst); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL ext_busy_window: %0d cycles wrong, required 0", bad_busy); end
    checks++;
    if (rec_sel[8] !== 3'd0) begin errors++; $display("FAIL ext_sel_early: got %0d, required 0", rec_sel[8]); end
    checks++;
    if (rec_sel[9] !== 3'd3 || rec_sel2[9] !== 3'd1) begin
      errors++; $display("FAIL ext_sel_load: got %0d/%0d, required 3/1", rec_sel[9], rec_sel2[9]);
    end
    checks++;
    if (rec_ready[10] !== 1'b0 || rec_ready[11] !== 1'b1) begin
      errors++; $display("FAIL ext_ready_return: got %b%b, required 01", rec_ready[10], rec_ready[11]);
    end
    checks++;
    if (rec_err[14] !== 1'b0) begin errors++; $display("FAIL ext_err: got %b, required 0", rec_err[14]); end
  endtask

  task automatic test_pll_request();
    int bad_rst = 0;
    // pll_lock high early: must not shorten SETTLE in this build
    run_req(1'b1, 3'd2, 3'd5, 16'd10, 30, 2);
    for (int c = 0; c <= 30; c++) if (rec_rst[c] !== (c >= 1 && c <= 23)) bad_rst++;
    checks++;
    if (first_done(30) != 24) begin errors++; $display("FAIL pll_done_cycle: got %0d, required 24", first_done(30)); end
    checks++;
    if (count_done(30) != 1) begin errors++; $display("FAIL pll_done_count: got %0d, required 1", count_done(30)); end
    checks++;
    if (first_ecs_low(30) != 20) begin errors++; $display("FAIL pll_switch_cycle: got %0d, required 20", first_ecs_low(30)); end
    checks++;
    if (rec_ecs[30] !== 1'b0) begin errors++; $display("FAIL pll_stays_on_pll: got %b, required 0", rec_ecs[30]); end
    checks++;
    if (bad_rst != 0) begin errors++; $display("FAIL pll_reset_window: %0d cycles wrong, required 0", bad_rst); end
    checks++;
    if (rec_sel[8] !== 3'd3) begin errors++; $display("FAIL pll_sel_early: got %0d, required 3", rec_sel[8]); end
    checks++;
    if (rec_sel[9] !== 3'd2 || rec_sel2[9] !== 3'd5) begin
      errors++; $display("FAIL pll_sel_load: got %0d/%0d, required 2/5", rec_sel[9], rec_sel2[9]);
    end
    checks++;
    if (rec_state[18] !== ST_SETTLE || rec_state[19] !== ST_SWITCH) begin
      errors++; $display("FAIL pll_state_seq: got %0d,%0d, required 4,5", rec_state[18], rec_state[19]);
    end
    checks++;
    if (rec_ready[25] !== 1'b1) begin errors++; $display("FAIL pll_ready_return: got %b, required 1", rec_ready[25]); end
    checks++;
    if (rec_err[30] !== 1'b0) begin errors++; $display("FAIL pll_err_tied: got %b, required 0", rec_err[30]); end
  endtask

  task automatic test_lock_timeout();
    int bad_ecs = 0, sw = 0;
    run_req(1'b1, 3'd1, 3'd2, 16'd100, 115, -1);
    for (int c = 5; c <= 115; c++) if (rec_ecs[c] !== 1'b1) bad_ecs++;
    for (int c = 0; c <= 115; c++) if (rec_state[c] === ST_SWITCH) sw++;
    checks++;
    if (first_done(115) != 110) begin errors++; $display("FAIL to_done_cycle: got %0d, required 110", first_done(115)); end
    checks++;
    if (rec_err[108] !== 1'b0 || rec_err[109] !== 1'b1 || rec_err[115] !== 1'b1) begin
      errors++; $display("FAIL to_err: got %b%b%b, required 011", rec_err[108], rec_err[109], rec_err[115]);
    end
    checks++;
    if (bad_ecs != 0) begin errors++; $display("FAIL to_ext_clk_sel: %0d cycles not 1, required 0", bad_ecs); end
    checks++;
    if (sw != 0) begin errors++; $display("FAIL to_no_switch: %0d SWITCH cycles, required 0", sw); end
  endtask

  task automatic test_lock_early();
    run_req(1'b1, 3'd2, 3'd3, 16'd100, 20, 11);
    checks++;
    if (rec_err[0] !== 1'b0) begin errors++; $display("FAIL lk_err_clear: got %b, required 0", rec_err[0]); end
    checks++;
    if (rec_state[11] !== ST_SETTLE || rec_state[12] !== ST_SWITCH) begin
      errors++; $display("FAIL lk_switch_entry: got %0d,%0d, required 4,5", rec_state[11], rec_state[12]);
    end
    checks++;
    if (first_ecs_low(20) != 13) begin errors++; $display("FAIL lk_ecs_low: got %0d, required 13", first_ecs_low(20)); end
    checks++;
    if (first_done(20) != 17) begin errors++; $display("FAIL lk_done_cycle: got %0d, required 17", first_done(20)); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, exp_v;
    int m;
    wait_ready();
    ifc.req_valid     = 1'b1;
    ifc.req_use_pll   = 1'b0;
    ifc.req_sel       = 3'd4;
    ifc.req_sel2      = 3'd2;
    ifc.settle_cycles = 16'd5;
    for (int c = 0; c < 40; c++) begin
      @(posedge ext_clk); #1;
      m     = c % 12;
      exp_v = {(m == 11), (m >= 1 && m <= 9), (m == 10)};
      obs   = {ifc.req_ready, busy, done};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL b2b_ready_busy_done cycle %0d: got %b, required %b", c, obs, exp_v);
      end
      checks++;
      if ((ifc.req_ready & busy) !== 1'b0) begin
        errors++; $display("FAIL b2b_overlap cycle %0d: ready&busy=%b, required 0", c, ifc.req_ready & busy);
      end
    end
    ifc.req_valid = 1'b0;
    checks++;
    if (sel !== 3'd4) begin errors++; $display("FAIL b2b_sel: got %0d, required 4", sel); end
  endtask

  task automatic test_abort();
    logic [11:0] obs;
    int seen_done = 0;
    run_req(1'b1, 3'd6, 3'd7, 16'd10, 12, -1);
    checks++;
    if (rec_state[12] !== ST_SETTLE || rec_sel[12] !== 3'd6) begin
      errors++; $display("FAIL abort_pre: state %0d sel %0d, required 4 and 6", rec_state[12], rec_sel[12]);
    end
    resetb = 1'b0;
    @(posedge ext_clk); #1;
    obs = {ext_clk_sel, sel, sel2, ext_reset, busy, done, err, ifc.req_ready};
    checks++;
    if (obs !== 12'b1_000_000_0_0_0_0_0) begin
      errors++; $display("FAIL abort_outputs: got %b, required 100000000000", obs);
    end
    @(posedge ext_clk); #1;
    if (done === 1'b1) seen_done++;
    resetb = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge ext_clk); #1;
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL abort_no_done: %0d pulses, required 0", seen_done); end
    checks++;
    if (ifc.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: ready %b busy %b, required 1 0", ifc.req_ready, busy);
    end
  endtask

  initial begin
    resetb            = 1'b0;
    pll_lock          = 1'b0;
    ifc.req_valid     = 1'b0;
    ifc.req_use_pll   = 1'b0;
    ifc.req_sel       = 3'd0;
    ifc.req_sel2      = 3'd0;
    ifc.settle_cycles = 16'd0;
    test_reset();
    test_ext_only();
`ifdef CLKSW_LOCK_CHECK_EN
    test_lock_timeout();
    test_lock_early();
`else
    test_pll_request();
`endif
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
